// File: rtl/exu_alu_cmt_pipe.sv
// rtl/exu_alu_cmt_pipe.sv - 2-entry registered buffer between ALU result stage and commit
module exu_alu_cmt_pipe #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req,
  input  logic                  alu_i_valid,
  output logic                  alu_i_ready,
  input  logic [PC_SIZE-1:0]    alu_i_pc,
  input  logic [INSTR_SIZE-1:0] alu_i_instr,
  input  logic                  alu_i_pc_vld,
  input  logic [XLEN-1:0]       alu_i_imm,
  input  logic                  alu_i_bjp,
  input  logic                  alu_i_bjp_prdt,
  input  logic                  alu_i_ebreak,
  output logic                  cmt_o_valid,
  input  logic                  cmt_o_ready,
  output logic [PC_SIZE-1:0]    cmt_o_pc,
  output logic [INSTR_SIZE-1:0] cmt_o_instr,
  output logic                  cmt_o_pc_vld,
  output logic [XLEN-1:0]       cmt_o_imm,
  output logic                  cmt_o_bjp,
  output logic                  cmt_o_bjp_prdt,
  output logic                  cmt_o_ebreak,
  output logic [1:0]            occupancy,
  output logic                  halted
);

  // Slot storage: one register per payload field, indexed by the 1-bit pointers.
  logic [PC_SIZE-1:0]    pc_q       [2];
  logic [INSTR_SIZE-1:0] instr_q    [2];
  logic                  pc_vld_q   [2];
  logic [XLEN-1:0]       imm_q      [2];
  logic                  bjp_q      [2];
  logic                  bjp_prdt_q [2];
  logic                  ebreak_q   [2];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       halted_q;
  logic       run_q;
  logic       push;
  logic       pop;

  // run_q keeps the input closed during reset and opens it one cycle after release.
  assign alu_i_ready = run_q & (count != 2'd2) & ~flush_req & ~halted_q;
  assign cmt_o_valid = (count != 2'd0) & ~halted_q;
  assign push        = alu_i_valid & alu_i_ready;
  assign pop         = cmt_o_valid & cmt_o_ready;

  // Head payload is read straight from the slot registers, never from alu_i_*.
  assign cmt_o_pc       = pc_q[rd_ptr];
  assign cmt_o_instr    = instr_q[rd_ptr];
  assign cmt_o_pc_vld   = pc_vld_q[rd_ptr];
  assign cmt_o_imm      = imm_q[rd_ptr];
  assign cmt_o_bjp      = bjp_q[rd_ptr];
  assign cmt_o_bjp_prdt = bjp_prdt_q[rd_ptr];
  assign cmt_o_ebreak   = ebreak_q[rd_ptr];
  assign occupancy      = count;
  assign halted         = halted_q;

  // Slot write on accept; slots are cleared on reset so the idle payload reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        pc_q[i]       <= '0;
        instr_q[i]    <= '0;
        pc_vld_q[i]   <= 1'b0;
        imm_q[i]      <= '0;
        bjp_q[i]      <= 1'b0;
        bjp_prdt_q[i] <= 1'b0;
        ebreak_q[i]   <= 1'b0;
      end
    end else if (push) begin
      pc_q[wr_ptr]       <= alu_i_pc;
      instr_q[wr_ptr]    <= alu_i_instr;
      pc_vld_q[wr_ptr]   <= alu_i_pc_vld;
      imm_q[wr_ptr]      <= alu_i_imm;
      bjp_q[wr_ptr]      <= alu_i_bjp;
      bjp_prdt_q[wr_ptr] <= alu_i_bjp_prdt;
      ebreak_q[wr_ptr]   <= alu_i_ebreak;
    end
  end

  // Pointers, count, halt and run flags; a flush empties the buffer after any same-cycle pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      halted_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (pop && cmt_o_ebreak) begin
        halted_q <= 1'b1;
      end
      if (flush_req) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          wr_ptr <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        if (push && !pop) begin
          count <= count + 2'd1;
        end else if (pop && !push) begin
          count <= count - 2'd1;
        end
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (count == 2'd2)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(pop && !push && (count == 2'd0)));
  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    count <= 2'd2);

endmodule
